avalon_burst_slave: RTL and testbench
=====================================

// Module: avalon_burst_slave
// PURPOSE
// - Parametrised Avalon-MM slave front end with single and burst transfers in both directions.
// - Adds waitrequest back-pressure, bounds checking over the whole burst, and error responses.
// - Sits between the Avalon fabric and the accelerator's local memory/register file (mem_* port).
// - mem_rdata returns one cycle after mem_rena.
// PARAMETERS
// AW         11       address width (word addresses)
// DW         32       data width
// BCW        10       burstcount width
// MIN_ADDR   11'h001  lowest legal address (address 0 is reserved)
// MAX_ADDR   11'h62B  highest legal address
// MAX_BURST  256      largest legal burstcount
// PORTS
// clk                 in   1    system clock
// n_rst               in   1    asynchronous reset, active-low
// address             in   AW   beat-0 address of the transfer
// read                in   1    read command
// write               in   1    write command / write data beat
// beginbursttransfer  in   1    informational only; not used for decode
// burstcount          in   BCW  beats in transfer; 0 is treated as 1
// writedata           in   DW   write data
// waitrequest         out  1    slave stall; command/beat accepted when waitrequest=0
// readdata            out  DW   read data
// readdatavalid       out  1    one read beat valid
// writeresponsevalid  out  1    write burst complete, response valid
// response            out  2    2'b00 OKAY, 2'b11 DECODEERROR
// mem_addr            out  AW   local memory address
// mem_rena            out  1    local read strobe
// mem_wena            out  1    local write strobe
// mem_wdata           out  DW   local write data
// mem_rdata           in   DW   local read data (1-cycle latency)
// BEHAVIOUR
// - Clock and reset: one clock domain, clk. Reset is asynchronous, active-low, on n_rst.
// - Reset values: state=IDLE; all outputs 0, including waitrequest.
// - Reset mid-burst aborts the burst silently; no response is issued.
// - Outputs are registered, except waitrequest, which decodes from state.
// - States:
//   - IDLE: waitrequest=0.
//   - RD, RD_ERR: waitrequest=1.
//   - WR, WR_ERR: waitrequest=0.
//   - WR_RESP: waitrequest=1.
// - Accept: a command is accepted in IDLE on a cycle where read or write is high.
//   - On accept, latch base=address and N=burstcount (0->1).
//   - write has priority when read and write are both high; the read is dropped.
// - Range check (AW+1 bit arithmetic, no wrap). The transfer is legal iff all of:
//   - base >= MIN_ADDR
//   - base+N-1 <= MAX_ADDR
//   - N <= MAX_BURST
// - Read timeline (accept at cycle T):
//   - Legal -> RD: mem_rena=1 with mem_addr=base+i at T+1..T+N.
//   - readdatavalid=1, readdata=mem_rdata, response=OKAY at T+2..T+N+1.
//   - Return to IDLE at T+N+2.
// - Illegal read -> RD_ERR: N beats at T+1..T+N with readdatavalid=1, readdata=0, response=DECODEERROR.
//   - mem_rena stays 0; then IDLE.
// - Write beats: the IDLE accept cycle carries beat 0. Later beats are counted only on cycles with write=1.
//   - Gaps (write=0) are allowed and do not advance the count.
//   - Legal: mem_wena=1 with mem_addr=base+i and mem_wdata=beat i, one cycle after each beat.
//   - Illegal -> WR_ERR: all N beats are still accepted (drained); mem_wena stays 0.
// - Write response: after beat N-1 is accepted, enter WR_RESP for 1 cycle.
//   - writeresponsevalid=1, response=OKAY (legal) or DECODEERROR (illegal); then IDLE.
//   - For N=1, accept at T gives mem_wena at T+1 and writeresponsevalid at T+1.
// - read asserted during WR or WR_ERR is ignored.
// - Commands presented while waitrequest=1 are not accepted. The master must hold them.
// - Beat counter: counts 0..N-1. The last-beat flag is (count==N-1) and is combinational.
// - response is 2'b00 whenever no valid strobe is asserted.
// STRUCTURE
// - avalon_pkg (shared package) holds:
//   - typedef enum logic [2:0] avalon_state_t {IDLE,RD,RD_ERR,WR,WR_ERR,WR_RESP}
//   - localparams RESP_OKAY=2'b00 and RESP_DECODEERR=2'b11
//   - function in_range(base,n,min,max,maxburst)
// - Sub-module avalon_burst_counter: BCW-bit counter with clear, enable and rollover_val=N.
//   - It asserts last_beat and offset; offset is added to base for mem_addr.
// - Top level holds the FSM, the base/N registers and the output registers.
// TESTING
// 1. Single read, addr=11'h010, burstcount=1, mem[0x10]=32'hDEADBEEF.
//    -> mem_rena at T+1; readdatavalid, readdata=DEADBEEF, resp=00 at T+2; waitrequest low at T+3.
// 2. Burst write, addr=11'h100, burstcount=4, data 1..4, write low for 2 cycles after beat 1.
//    -> mem_wena x4 at 0x100..0x103 in order; one writeresponsevalid, resp=00, after beat 4.
// 3. Burst read, addr=11'h628, burstcount=5 (ends at 0x62C > MAX_ADDR).
//    -> 5 readdatavalid beats, readdata=0, resp=11; mem_rena never asserted.
// 4. Write to addr=0 with burstcount=0 (treated as 1).
//    -> 1 beat drained; no mem_wena; writeresponsevalid with resp=11.
// 5. read and write both high in IDLE, addr=11'h020, burstcount=1.
//    -> write performed; no readdatavalid.
// 6. Burst read of 8 beats, n_rst low after beat 3.
//    -> all outputs 0 asynchronously; the next read after reset behaves as in test 1.

Source files
------------

// File: rtl/avalon_pkg.sv
// Shared types and helpers for the Avalon-MM burst slave front end.
// Holds the FSM state encoding, the response codes and the burst range check.
package avalon_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_ERR  = 3'd2,
        WR      = 3'd3,
        WR_ERR  = 3'd4,
        WR_RESP = 3'd5
    } avalon_state_t;

    localparam logic [1:0] RESP_OKAY      = 2'b00;
    localparam logic [1:0] RESP_DECODEERR = 2'b11;

    // Operands are zero-extended to 32 bits, so base+n-1 can never wrap.
    function automatic logic in_range(input logic [31:0] base,
                                      input logic [31:0] n,
                                      input logic [31:0] min_addr,
                                      input logic [31:0] max_addr,
                                      input logic [31:0] max_burst);
        return (base >= min_addr) &&
               ((base + n - 32'd1) <= max_addr) &&
               (n <= max_burst);
    endfunction

endpackage

// File: rtl/avalon_burst_counter.sv
// Beat counter for one burst: counts 0..rollover_val-1, then wraps to 0.
// offset is the current beat index, last_beat flags the final beat.
module avalon_burst_counter #(
    parameter int BCW = 10
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic           clr,
    input  logic           en,
    input  logic [BCW-1:0] rollover_val,
    output logic           last_beat,
    output logic [BCW-1:0] offset
);

    logic [BCW-1:0] count;

    assign last_beat = (count == rollover_val - BCW'(1));
    assign offset    = count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= last_beat ? '0 : count + BCW'(1);
        end
    end

endmodule

// File: rtl/avalon_burst_slave.sv
// Avalon-MM slave front end: single and burst reads/writes onto a local memory port,
// with whole-burst range checking, waitrequest back-pressure and DECODEERROR responses.
module avalon_burst_slave
    import avalon_pkg::*;
#(
    parameter int              AW        = 11,
    parameter int              DW        = 32,
    parameter int              BCW       = 10,
    parameter logic [AW-1:0]   MIN_ADDR  = 11'h001,
    parameter logic [AW-1:0]   MAX_ADDR  = 11'h62B,
    parameter int              MAX_BURST = 256
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic [AW-1:0]  address,
    input  logic           read,
    input  logic           write,
    input  logic           beginbursttransfer,
    input  logic [BCW-1:0] burstcount,
    input  logic [DW-1:0]  writedata,
    output logic           waitrequest,
    output logic [DW-1:0]  readdata,
    output logic           readdatavalid,
    output logic           writeresponsevalid,
    output logic [1:0]     response,
    output logic [AW-1:0]  mem_addr,
    output logic           mem_rena,
    output logic           mem_wena,
    output logic [DW-1:0]  mem_wdata,
    input  logic [DW-1:0]  mem_rdata
);

    avalon_state_t  state;
    logic [AW-1:0]  base_q;
    logic [BCW-1:0] n_q;
    logic [BCW-1:0] n_in;
    logic           legal_in;
    logic           accept;

    logic           cnt_clr;
    logic           cnt_en;
    logic [BCW-1:0] cnt_roll;
    logic           last_beat;
    logic [BCW-1:0] offset;
    logic [AW-1:0]  beat_addr;
    logic [AW-1:0]  next_rd_addr;

    // beginbursttransfer is informational; burstcount alone drives decode.
    logic unused_inputs;
    assign unused_inputs = beginbursttransfer;

    assign n_in     = (burstcount == '0) ? BCW'(1) : burstcount;
    assign legal_in = in_range(32'(address), 32'(n_in), 32'(MIN_ADDR),
                               32'(MAX_ADDR), 32'(MAX_BURST));
    assign accept   = (state == IDLE) && (read || write);

    assign waitrequest = (state == RD) || (state == RD_ERR) || (state == WR_RESP);

    // Local memory answers one cycle after mem_rena, i.e. exactly when readdatavalid is up.
    assign readdata = (readdatavalid && (state == RD)) ? mem_rdata : '0;

    assign beat_addr    = base_q + AW'(offset);
    assign next_rd_addr = base_q + AW'(offset) + AW'(1);

    // In IDLE the burst length is not latched yet, so the counter sees the incoming one.
    assign cnt_roll = (state == IDLE) ? n_in : n_q;
    assign cnt_clr  = (state == IDLE) && !write;

    always_comb begin
        cnt_en = 1'b0;
        case (state)
            IDLE:       cnt_en = write;
            RD:         cnt_en = mem_rena;
            RD_ERR:     cnt_en = 1'b1;
            WR, WR_ERR: cnt_en = write;
            default:    cnt_en = 1'b0;
        endcase
    end

    avalon_burst_counter #(
        .BCW (BCW)
    ) u_counter (
        .clk          (clk),
        .n_rst        (n_rst),
        .clr          (cnt_clr),
        .en           (cnt_en),
        .rollover_val (cnt_roll),
        .last_beat    (last_beat),
        .offset       (offset)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            base_q <= address;
            n_q    <= n_in;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state              <= IDLE;
            readdatavalid      <= 1'b0;
            writeresponsevalid <= 1'b0;
            response           <= RESP_OKAY;
            mem_addr           <= '0;
            mem_rena           <= 1'b0;
            mem_wena           <= 1'b0;
            mem_wdata          <= '0;
        end else begin
            mem_wena           <= 1'b0;
            writeresponsevalid <= 1'b0;
            case (state)
                IDLE: begin
                    readdatavalid <= 1'b0;
                    response      <= RESP_OKAY;
                    mem_rena      <= 1'b0;
                    if (write) begin
                        mem_addr  <= address;
                        mem_wdata <= writedata;
                        mem_wena  <= legal_in;
                        if (last_beat) begin
                            state              <= WR_RESP;
                            writeresponsevalid <= 1'b1;
                            response           <= legal_in ? RESP_OKAY : RESP_DECODEERR;
                        end else begin
                            state <= legal_in ? WR : WR_ERR;
                        end
                    end else if (read) begin
                        if (legal_in) begin
                            state    <= RD;
                            mem_rena <= 1'b1;
                            mem_addr <= address;
                        end else begin
                            state         <= RD_ERR;
                            readdatavalid <= 1'b1;
                            response      <= RESP_DECODEERR;
                        end
                    end
                end
                RD: begin
                    readdatavalid <= mem_rena;
                    response      <= RESP_OKAY;
                    if (mem_rena) begin
                        if (last_beat) begin
                            mem_rena <= 1'b0;
                        end else begin
                            mem_addr <= next_rd_addr;
                        end
                    end else begin
                        // last read beat is on the bus this cycle; fabric sees it, then IDLE
                        state <= IDLE;
                    end
                end
                RD_ERR: begin
                    if (last_beat) begin
                        readdatavalid <= 1'b0;
                        response      <= RESP_OKAY;
                        state         <= IDLE;
                    end
                end
                WR, WR_ERR: begin
                    if (write) begin
                        mem_addr  <= beat_addr;
                        mem_wdata <= writedata;
                        mem_wena  <= (state == WR);
                        if (last_beat) begin
                            state              <= WR_RESP;
                            writeresponsevalid <= 1'b1;
                            response           <= (state == WR) ? RESP_OKAY : RESP_DECODEERR;
                        end
                    end
                end
                WR_RESP: begin
                    response <= RESP_OKAY;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_burst_slave.sv
// Self-checking bench for avalon_burst_slave: directed corner cases, a boundary
// vector table and randomized transactions against a transaction-level reference.
module tb_avalon_burst_slave;

    localparam int LOGN = 8192;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [10:0] address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic        beginbursttransfer = 1'b0;
    logic [9:0]  burstcount = '0;
    logic [31:0] writedata = '0;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        writeresponsevalid;
    logic [1:0]  response;
    logic [10:0] mem_addr;
    logic        mem_rena;
    logic        mem_wena;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    avalon_burst_slave dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .address            (address),
        .read               (read),
        .write              (write),
        .beginbursttransfer (beginbursttransfer),
        .burstcount         (burstcount),
        .writedata          (writedata),
        .waitrequest        (waitrequest),
        .readdata           (readdata),
        .readdatavalid      (readdatavalid),
        .writeresponsevalid (writeresponsevalid),
        .response           (response),
        .mem_addr           (mem_addr),
        .mem_rena           (mem_rena),
        .mem_wena           (mem_wena),
        .mem_wdata          (mem_wdata),
        .mem_rdata          (mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'hDEADBEEF;
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A_0000;
    endfunction

    // Local memory environment: 1-cycle read latency.
    logic [31:0] mem [0:2047];
    logic        mem_load = 1'b0;
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 2048; i++) mem[i] <= init_word(i);
        end else begin
            if (mem_wena) mem[mem_addr] <= mem_wdata;
            if (mem_rena) mem_rdata <= mem[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event logs gathered from the DUT outputs
    logic [31:0] rd_data_log [LOGN];
    logic [1:0]  rd_resp_log [LOGN];
    int          rd_cyc_log  [LOGN];
    int          rd_n = 0;
    logic [10:0] ra_addr_log [LOGN];
    int          ra_cyc_log  [LOGN];
    int          ra_n = 0;
    logic [10:0] wa_addr_log [LOGN];
    logic [31:0] wa_data_log [LOGN];
    int          wa_cyc_log  [LOGN];
    int          wa_n = 0;
    logic [1:0]  wr_resp_log [LOGN];
    int          wr_cyc_log  [LOGN];
    int          wr_n = 0;
    int          bad_resp_n = 0;

    always @(negedge clk) begin
        if (readdatavalid) begin
            rd_data_log[rd_n % LOGN] <= readdata;
            rd_resp_log[rd_n % LOGN] <= response;
            rd_cyc_log[rd_n % LOGN]  <= cyc;
            rd_n <= rd_n + 1;
        end
        if (mem_rena) begin
            ra_addr_log[ra_n % LOGN] <= mem_addr;
            ra_cyc_log[ra_n % LOGN]  <= cyc;
            ra_n <= ra_n + 1;
        end
        if (mem_wena) begin
            wa_addr_log[wa_n % LOGN] <= mem_addr;
            wa_data_log[wa_n % LOGN] <= mem_wdata;
            wa_cyc_log[wa_n % LOGN]  <= cyc;
            wa_n <= wa_n + 1;
        end
        if (writeresponsevalid) begin
            wr_resp_log[wr_n % LOGN] <= response;
            wr_cyc_log[wr_n % LOGN]  <= cyc;
            wr_n <= wr_n + 1;
        end
        if (!readdatavalid && !writeresponsevalid && response != 2'b00)
            bad_resp_n <= bad_resp_n + 1;
    end

    // Reference model state
    logic [31:0] model_mem [0:2047];
    logic [31:0] wbuf [1024];
    int n_checks = 0;
    int n_fail = 0;

    function automatic bit ref_legal(input int a, input int bc);
        int n;
        n = (bc == 0) ? 1 : bc;
        return (a >= 1) && (a + n - 1 <= 1579) && (n <= 256);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name, input int lim);
        int k;
        k = 0;
        while (waitrequest !== 1'b0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        check({name, " ready_timeout"}, 64'(k >= lim), 64'd0);
    endtask

    task automatic do_read(input int addr, input int bc, input bit legal, input string name);
        int n, rd0, ra0, wa0, wr0, br0, acc, bad_rd, bad_ra, got;
        n   = (bc == 0) ? 1 : bc;
        rd0 = rd_n; ra0 = ra_n; wa0 = wa_n; wr0 = wr_n; br0 = bad_resp_n;
        wait_ready({name, " pre"}, 50);
        address = 11'(addr); burstcount = 10'(bc); read = 1'b1; write = 1'b0;
        acc = cyc;
        @(posedge clk);
        @(negedge clk);
        read = 1'b0;
        wait_ready({name, " post"}, n + 10);
        got = rd_n - rd0;
        check({name, " rd_beats"}, 64'(got), 64'(n));
        bad_rd = 0;
        for (int i = 0; i < n && i < got; i++) begin
            int idx;
            idx = (rd0 + i) % LOGN;
            if (rd_data_log[idx] !== (legal ? model_mem[addr + i] : 32'h0) ||
                rd_resp_log[idx] !== (legal ? 2'b00 : 2'b11) ||
                rd_cyc_log[idx] != acc + (legal ? 2 : 1) + i)
                bad_rd++;
        end
        check({name, " rd_beats_wrong"}, 64'(bad_rd), 64'd0);
        check({name, " rena_count"}, 64'(ra_n - ra0), legal ? 64'(n) : 64'd0);
        bad_ra = 0;
        for (int i = 0; i < (ra_n - ra0) && i < n; i++) begin
            int idx;
            idx = (ra0 + i) % LOGN;
            if (ra_addr_log[idx] !== 11'(addr + i) || ra_cyc_log[idx] != acc + 1 + i) bad_ra++;
        end
        check({name, " rena_wrong"}, 64'(bad_ra), 64'd0);
        check({name, " no_wena"}, 64'(wa_n - wa0), 64'd0);
        check({name, " no_wrv"}, 64'(wr_n - wr0), 64'd0);
        check({name, " idle_resp"}, 64'(bad_resp_n - br0), 64'd0);
    endtask

    task automatic do_write(input int addr, input int bc, input bit legal, input string name,
                            input bit seq_data, input int gap_after, input bit rand_gaps,
                            input bit also_read);
        int n, rd0, ra0, wa0, wr0, br0, acc_last, gaps, bad_wa;
        n = (bc == 0) ? 1 : bc;
        for (int i = 0; i < n; i++) wbuf[i] = seq_data ? 32'(i + 1) : $urandom;
        rd0 = rd_n; ra0 = ra_n; wa0 = wa_n; wr0 = wr_n; br0 = bad_resp_n;
        wait_ready({name, " pre"}, 50);
        address = 11'(addr); burstcount = 10'(bc);
        write = 1'b1; writedata = wbuf[0]; read = also_read;
        acc_last = cyc;
        @(posedge clk);
        @(negedge clk);
        read = 1'b0;
        for (int i = 1; i < n; i++) begin
            gaps = rand_gaps ? int'($urandom_range(0, 2)) : ((i - 1 == gap_after) ? 2 : 0);
            write = 1'b0;
            repeat (gaps) begin
                read = rand_gaps ? 1'($urandom_range(0, 1)) : 1'b0;
                @(posedge clk);
                @(negedge clk);
            end
            write = 1'b1; writedata = wbuf[i];
            read = rand_gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            acc_last = cyc;
            @(posedge clk);
            @(negedge clk);
        end
        write = 1'b0; read = 1'b0;
        wait_ready({name, " post"}, 20);
        check({name, " wena_count"}, 64'(wa_n - wa0), legal ? 64'(n) : 64'd0);
        bad_wa = 0;
        for (int i = 0; i < (wa_n - wa0) && i < n; i++) begin
            int idx;
            idx = (wa0 + i) % LOGN;
            if (wa_addr_log[idx] !== 11'(addr + i) || wa_data_log[idx] !== wbuf[i]) bad_wa++;
        end
        check({name, " wena_wrong"}, 64'(bad_wa), 64'd0);
        if (legal && (wa_n - wa0) > 0)
            check({name, " last_wena_cyc"}, 64'(wa_cyc_log[(wa_n - 1) % LOGN]), 64'(acc_last + 1));
        check({name, " wrv_count"}, 64'(wr_n - wr0), 64'd1);
        if (wr_n > wr0) begin
            check({name, " wr_resp"}, 64'(wr_resp_log[wr0 % LOGN]), legal ? 64'd0 : 64'd3);
            check({name, " wrv_cyc"}, 64'(wr_cyc_log[wr0 % LOGN]), 64'(acc_last + 1));
        end
        check({name, " no_rdv"}, 64'(rd_n - rd0), 64'd0);
        check({name, " no_rena"}, 64'(ra_n - ra0), 64'd0);
        check({name, " idle_resp"}, 64'(bad_resp_n - br0), 64'd0);
        if (legal) for (int i = 0; i < n; i++) model_mem[addr + i] = wbuf[i];
    endtask

    task automatic single_read_timing(input string name);
        wait_ready({name, " pre"}, 50);
        address = 11'h010; burstcount = 10'd1; read = 1'b1; write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        read = 1'b0;
        check({name, " T1 mem_rena"}, 64'(mem_rena), 64'd1);
        check({name, " T1 mem_addr"}, 64'(mem_addr), 64'h010);
        check({name, " T1 rdv"}, 64'(readdatavalid), 64'd0);
        check({name, " T1 waitreq"}, 64'(waitrequest), 64'd1);
        @(negedge clk);
        check({name, " T2 rdv"}, 64'(readdatavalid), 64'd1);
        check({name, " T2 readdata"}, 64'(readdata), 64'hDEADBEEF);
        check({name, " T2 response"}, 64'(response), 64'd0);
        check({name, " T2 mem_rena"}, 64'(mem_rena), 64'd0);
        @(negedge clk);
        check({name, " T3 waitreq"}, 64'(waitrequest), 64'd0);
        check({name, " T3 rdv"}, 64'(readdatavalid), 64'd0);
    endtask

    typedef struct {
        bit is_wr;
        int addr;
        int bc;
        bit legal;
    } vec_t;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];
        int rd0, k;

        // Reset state
        #2;
        check("reset waitrequest", 64'(waitrequest), 64'd0);
        check("reset outputs", {readdatavalid, writeresponsevalid, response, mem_addr,
                                mem_rena, mem_wena}, 64'd0);
        check("reset data", {readdata, mem_wdata}, 64'd0);
        mem_load = 1'b1;
        for (int i = 0; i < 2048; i++) model_mem[i] = init_word(i);
        @(posedge clk);
        @(negedge clk);
        mem_load = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        single_read_timing("t1");
        do_write('h100, 4, 1'b1, "t2", 1'b1, 0, 1'b0, 1'b0);
        do_read('h100, 4, 1'b1, "t2_readback");
        do_read('h628, 5, 1'b0, "t3");
        do_write('h000, 0, 1'b0, "t4", 1'b0, -1, 1'b0, 1'b0);
        do_write('h020, 1, 1'b1, "t5", 1'b0, -1, 1'b0, 1'b1);

        // Reset in the middle of an 8-beat read
        rd0 = rd_n;
        address = 11'h200; burstcount = 10'd8; read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        read = 1'b0;
        k = 0;
        while (rd_n - rd0 < 3 && k < 30) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("t6 beats_before_reset", 64'(rd_n - rd0), 64'd3);
        n_rst = 1'b0;
        #1;
        check("t6 async waitrequest", 64'(waitrequest), 64'd0);
        check("t6 async outputs", {readdatavalid, writeresponsevalid, response, mem_addr,
                                   mem_rena, mem_wena}, 64'd0);
        check("t6 async data", {readdata, mem_wdata}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        check("t6 no_beats_in_reset", 64'(rd_n - rd0), 64'd3);
        n_rst = 1'b1;
        @(negedge clk);
        single_read_timing("t6_after");

        // Boundary vector table
        vecs.push_back('{1'b0, 'h001,   1, 1'b1});
        vecs.push_back('{1'b0, 'h000,   1, 1'b0});
        vecs.push_back('{1'b0, 'h62B,   1, 1'b1});
        vecs.push_back('{1'b0, 'h62B,   2, 1'b0});
        vecs.push_back('{1'b0, 'h62C,   1, 1'b0});
        vecs.push_back('{1'b0, 'h62B,   0, 1'b1});
        vecs.push_back('{1'b0, 'h001, 256, 1'b1});
        vecs.push_back('{1'b0, 'h001, 257, 1'b0});
        vecs.push_back('{1'b1, 'h62B,   1, 1'b1});
        vecs.push_back('{1'b1, 'h62A,   3, 1'b0});
        vecs.push_back('{1'b1, 'h001, 256, 1'b1});
        vecs.push_back('{1'b1, 'h005, 257, 1'b0});
        vecs.push_back('{1'b1, 'h000,   2, 1'b0});
        vecs.push_back('{1'b1, 'h62A,   2, 1'b1});
        foreach (vecs[i]) begin
            if (vecs[i].is_wr)
                do_write(vecs[i].addr, vecs[i].bc, vecs[i].legal, $sformatf("vec%0d", i),
                         1'b0, -1, 1'b1, 1'b0);
            else
                do_read(vecs[i].addr, vecs[i].bc, vecs[i].legal, $sformatf("vec%0d", i));
        end
        do_read('h001, 256, 1'b1, "vec_readback");

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            int sel, a, bc;
            bit is_wr;
            is_wr = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      a = int'($urandom_range(0, 3));
            else if (sel == 1) a = int'($urandom_range('h620, 'h7FF));
            else               a = int'($urandom_range(1, 'h600));
            bc = (sel == 2) ? int'($urandom_range(250, 260)) : int'($urandom_range(0, 9));
            if (is_wr)
                do_write(a, bc, ref_legal(a, bc), $sformatf("rnd%0d_wr", t), 1'b0, -1, 1'b1, 1'b0);
            else
                do_read(a, bc, ref_legal(a, bc), $sformatf("rnd%0d_rd", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
